// File: rtl/mem_resp_queue.sv
// mem_resp_queue: DEPTH-entry in-order memory response queue with load alignment; define MEM_LWLR_EN to build LWL/LWR merging and in_rt storage
module mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [6:0]                 in_load_type,
  input  logic                       in_store,
  input  logic                       in_exc,
  input  logic [1:0]                 in_offset,
  input  logic [31:0]                in_rt,
  input  logic [31:0]                in_result,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       data_ok,
  input  logic [31:0]                rdata,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_exc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       resp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [6:0]       typ_q [DEPTH];
  logic [1:0]       off_q [DEPTH];
  logic [31:0]      res_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] exc_q, exp_q, done_q;
  logic [PW-1:0]    head, tail, rptr;
  logic [CW-1:0]    drop_cnt, waiting;
  logic             found, accept, pop, drop_hit, match, new_exp;
  logic [4:0]       sh;
  logic [7:0]       bt;
  logic [15:0]      hw;
  logic [31:0]      aligned;
`ifdef MEM_LWLR_EN
  logic [31:0]      rt_q [DEPTH];
`else
  logic             unused_rt;
  assign unused_rt = ^in_rt;
`endif
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  always_comb begin
    found = 1'b0;
    rptr = head;
    waiting = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count) && exp_q[slot(head, k)] && !done_q[slot(head, k)]) begin
        waiting = waiting + CW'(1);
        if (!found) begin
          found = 1'b1;
          rptr = slot(head, k);
        end
      end
    end
  end
  always_comb begin
    sh = {off_q[rptr], 3'b000};
    bt = 8'(rdata >> sh);
    hw = off_q[rptr][1] ? rdata[31:16] : rdata[15:0];
    aligned = typ_q[rptr][6] ? {{24{bt[7]}}, bt} :
              typ_q[rptr][5] ? {24'd0, bt} :
              typ_q[rptr][4] ? {{16{hw[15]}}, hw} :
              typ_q[rptr][3] ? {16'd0, hw} : rdata;
`ifdef MEM_LWLR_EN
    if (typ_q[rptr][1]) aligned = (rdata << (5'd24 - sh)) | (rt_q[rptr] & (32'h00FF_FFFF >> sh));
    if (typ_q[rptr][0]) aligned = (rdata >> sh) | (rt_q[rptr] & ~(32'hFFFF_FFFF >> sh));
`endif
  end
  assign drop_hit   = data_ok && drop_cnt != '0;
  assign match      = data_ok && !drop_hit && found;
  assign new_exp    = (|in_load_type || in_store) && !in_exc;
  assign in_allowin = !flush && ({1'b0, count} + {1'b0, drop_cnt} < (CW+1)'(DEPTH));
  assign accept     = in_valid && in_allowin;
  assign out_valid  = count != '0 && done_q[head];
  assign pop        = out_valid && out_ready && !flush;
  assign out_result = res_q[head];
  assign out_tag    = tag_q[head];
  assign out_exc    = exc_q[head];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      drop_cnt <= '0;
      resp_err <= 1'b0;
      exc_q <= '0;
      exp_q <= '0;
      done_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ_q[i] <= '0;
        off_q[i] <= '0;
        res_q[i] <= '0;
        tag_q[i] <= '0;
`ifdef MEM_LWLR_EN
        rt_q[i] <= '0;
`endif
      end
    end else begin
      if (data_ok && !drop_hit && !found) resp_err <= 1'b1;
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        drop_cnt <= drop_cnt + waiting - CW'(drop_hit || match);
      end else begin
        drop_cnt <= drop_cnt - CW'(drop_hit);
        if (match) begin
          done_q[rptr] <= 1'b1;
          if (|typ_q[rptr]) res_q[rptr] <= aligned;
        end
        if (accept) begin
          typ_q[tail] <= in_load_type;
          off_q[tail] <= in_offset;
          res_q[tail] <= in_result;
          tag_q[tail] <= in_tag;
          exc_q[tail] <= in_exc;
          exp_q[tail] <= new_exp;
          done_q[tail] <= !new_exp;
`ifdef MEM_LWLR_EN
          rt_q[tail] <= in_rt;
`endif
          tail <= slot(tail, 1);
        end
        if (pop) head <= slot(head, 1);
        count <= count + CW'(accept) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_mem_resp_queue.sv
// tb_mem_resp_queue: table vectors, directed corner sequences and a random run against a queue-based reference model
module tb_mem_resp_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 64;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef MEM_LWLR_EN
  localparam bit LWLR = 1'b1;
`else
  localparam bit LWLR = 1'b0;
`endif
  localparam logic [6:0] T_LB = 7'b1000000, T_LBU = 7'b0100000, T_LH = 7'b0010000, T_LHU = 7'b0001000;
  localparam logic [6:0] T_LW = 7'b0000100, T_LWL = 7'b0000010, T_LWR = 7'b0000001, T_ALU = 7'b0000000;
  logic clk, resetn, in_valid, in_allowin, in_store, in_exc, data_ok, flush, out_valid, out_ready, out_exc, resp_err;
  logic [6:0] in_load_type;
  logic [1:0] in_offset;
  logic [31:0] in_rt, in_result, rdata, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [CW-1:0] count;
  int n_chk, n_fail;
  typedef struct {
    logic [6:0] typ;
    logic st;
    logic exc;
    logic [1:0] off;
    logic [31:0] rt;
    logic [31:0] res;
    logic [31:0] rd;
    logic [31:0] exp_res;
  } vec_t;
  typedef struct {
    logic [6:0] typ;
    logic exc;
    logic [1:0] off;
    logic [31:0] rt;
    logic [31:0] res;
    logic [63:0] tag;
    bit owes;
    bit done;
  } ent_t;
  vec_t vt[$];
  ent_t mq[$];
  int mdrop;
  bit merr;
  mem_resp_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_load_type(in_load_type), .in_store(in_store), .in_exc(in_exc), .in_offset(in_offset),
    .in_rt(in_rt), .in_result(in_result), .in_tag(in_tag), .data_ok(data_ok), .rdata(rdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_exc(out_exc), .count(count), .resp_err(resp_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    in_valid = 0; in_load_type = 0; in_store = 0; in_exc = 0; in_offset = 0; in_rt = 0;
    in_result = 0; in_tag = 0; data_ok = 0; rdata = 0; flush = 0; out_ready = 0;
  endtask
  task automatic push(input logic [6:0] t, input logic st, input logic ex, input logic [1:0] o,
                      input logic [31:0] rt, input logic [31:0] res, input logic [63:0] tg);
    in_valid = 1; in_load_type = t; in_store = st; in_exc = ex; in_offset = o; in_rt = rt;
    in_result = res; in_tag = tg;
    cyc();
    in_valid = 0;
  endtask
  task automatic resp(input logic [31:0] d);
    data_ok = 1; rdata = d;
    cyc();
    data_ok = 0;
  endtask
  function automatic logic [31:0] m_align(input logic [6:0] t, input int o, input logic [31:0] rt, input logic [31:0] d);
    logic [7:0] db[4], rb[4], r[4];
    logic [15:0] h;
    for (int j = 0; j < 4; j++) begin
      db[j] = d[8*j +: 8];
      rb[j] = rt[8*j +: 8];
    end
    h = {db[(o / 2) * 2 + 1], db[(o / 2) * 2]};
    if (t == T_LB) return {{24{db[o][7]}}, db[o]};
    if (t == T_LBU) return {24'd0, db[o]};
    if (t == T_LH) return {{16{h[15]}}, h};
    if (t == T_LHU) return {16'd0, h};
    if (LWLR && t == T_LWL) begin
      for (int j = 0; j < 4; j++) r[j] = (j >= 3 - o) ? db[j - (3 - o)] : rb[j];
      return {r[3], r[2], r[1], r[0]};
    end
    if (LWLR && t == T_LWR) begin
      for (int j = 0; j < 4; j++) r[j] = (j < 4 - o) ? db[j + o] : rb[j];
      return {r[3], r[2], r[1], r[0]};
    end
    return d;
  endfunction
  function automatic int m_waiting();
    int w = 0;
    foreach (mq[i]) if (mq[i].owes && !mq[i].done) w++;
    return w;
  endfunction
  task automatic m_step();
    bit accf, popf, hit;
    ent_t e;
    accf = in_valid && !flush && (mq.size() + mdrop < DEPTH);
    popf = !flush && mq.size() > 0 && mq[0].done && out_ready;
    if (data_ok) begin
      if (mdrop > 0) mdrop--;
      else begin
        hit = 0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!hit && mq[i].owes && !mq[i].done) begin
            hit = 1;
            e = mq[i];
            e.done = 1;
            if (e.typ != 0) e.res = m_align(e.typ, int'(e.off), e.rt, rdata);
            mq[i] = e;
          end
        end
        if (!hit) merr = 1;
      end
    end
    if (flush) begin
      mdrop += m_waiting();
      mq.delete();
    end else begin
      if (popf) void'(mq.pop_front());
      if (accf) begin
        e.typ = in_load_type; e.exc = in_exc; e.off = in_offset; e.rt = in_rt; e.res = in_result; e.tag = in_tag;
        e.owes = (in_load_type != 0 || in_store) && !in_exc;
        e.done = !e.owes;
        mq.push_back(e);
      end
    end
  endtask
  task automatic m_check();
    bit v;
    v = mq.size() > 0 && mq[0].done;
    chk("rnd_count", 64'(count), 64'(mq.size()));
    chk("rnd_allowin", 64'(in_allowin), 64'(!flush && (mq.size() + mdrop < DEPTH)));
    chk("rnd_out_valid", 64'(out_valid), 64'(v));
    chk("rnd_resp_err", 64'(resp_err), 64'(merr));
    if (v) begin
      chk("rnd_out_result", 64'(out_result), 64'(mq[0].res));
      chk("rnd_out_tag", out_tag, mq[0].tag);
      chk("rnd_out_exc", 64'(out_exc), 64'(mq[0].exc));
    end
  endtask
  initial begin
    int sel;
    n_chk = 0; n_fail = 0;
    idle();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    cyc();
    chk("rst_allowin", 64'(in_allowin), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_result", 64'(out_result), 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_exc", 64'(out_exc), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_resp_err", 64'(resp_err), 0);
    vt.push_back('{T_LB, 0, 0, 2'd3, 0, 0, 32'h8000_0000, 32'hFFFF_FF80});
    vt.push_back('{T_LBU, 0, 0, 2'd3, 0, 0, 32'h8000_0000, 32'h0000_0080});
    vt.push_back('{T_LB, 0, 0, 2'd1, 0, 0, 32'h0000_7F00, 32'h0000_007F});
    vt.push_back('{T_LH, 0, 0, 2'd2, 0, 0, 32'h8001_0000, 32'hFFFF_8001});
    vt.push_back('{T_LHU, 0, 0, 2'd2, 0, 0, 32'h8001_0000, 32'h0000_8001});
    vt.push_back('{T_LH, 0, 0, 2'd0, 0, 0, 32'h1234_F00F, 32'hFFFF_F00F});
    vt.push_back('{T_LW, 0, 0, 2'd0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vt.push_back('{T_ALU, 1, 0, 2'd0, 0, 32'h55, 32'hFFFF_FFFF, 32'h55});
    vt.push_back('{T_ALU, 0, 0, 2'd0, 0, 32'h77, 0, 32'h77});
    vt.push_back('{T_LW, 0, 1, 2'd0, 0, 32'h99, 0, 32'h99});
    vt.push_back('{T_LWL, 0, 0, 2'd1, 32'h1122_3344, 0, 32'hAABB_CCDD, LWLR ? 32'hCCDD_3344 : 32'hAABB_CCDD});
    vt.push_back('{T_LWL, 0, 0, 2'd0, 32'h1122_3344, 0, 32'hAABB_CCDD, LWLR ? 32'hDD22_3344 : 32'hAABB_CCDD});
    vt.push_back('{T_LWL, 0, 0, 2'd3, 32'h1122_3344, 0, 32'hAABB_CCDD, 32'hAABB_CCDD});
    vt.push_back('{T_LWR, 0, 0, 2'd1, 32'h1122_3344, 0, 32'hAABB_CCDD, LWLR ? 32'h11AA_BBCC : 32'hAABB_CCDD});
    vt.push_back('{T_LWR, 0, 0, 2'd3, 32'h1122_3344, 0, 32'hAABB_CCDD, LWLR ? 32'h1122_33AA : 32'hAABB_CCDD});
    vt.push_back('{T_LWR, 0, 0, 2'd0, 32'h1122_3344, 0, 32'hAABB_CCDD, 32'hAABB_CCDD});
    foreach (vt[i]) begin
      push(vt[i].typ, vt[i].st, vt[i].exc, vt[i].off, vt[i].rt, vt[i].res, 64'(i + 1));
      if ((vt[i].typ != 0 || vt[i].st) && !vt[i].exc) resp(vt[i].rd);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(vt[i].exp_res));
      chk($sformatf("vec%0d_exc", i), 64'(out_exc), 64'(vt[i].exc));
      chk($sformatf("vec%0d_tag", i), out_tag, 64'(i + 1));
      out_ready = 1;
      cyc();
      out_ready = 0;
      chk($sformatf("vec%0d_empty", i), 64'(count), 0);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_load_type = T_ALU; in_store = 0; in_exc = 0; in_result = 32'(32'h100 + i); in_tag = 64'(i);
      cyc();
      chk("b2b_valid", 64'(out_valid), 1);
      chk("b2b_count", 64'(count), 1);
      chk("b2b_result", 64'(out_result), 64'(32'h100 + i));
    end
    in_valid = 0;
    cyc();
    chk("b2b_drained", 64'(count), 0);
    out_ready = 0;
    push(T_LW, 0, 0, 2'd0, 0, 0, 64'hA);
    push(T_ALU, 0, 0, 2'd0, 0, 32'hA1, 64'hB);
    push(T_LB, 0, 0, 2'd3, 0, 0, 64'hC);
    chk("ooo_count", 64'(count), 3);
    chk("ooo_wait", 64'(out_valid), 0);
    resp(32'h80FF_1234);
    chk("ooo_r0", 64'(out_result), 64'h80FF_1234);
    chk("ooo_t0", out_tag, 64'hA);
    out_ready = 1;
    resp(32'h8000_0000);
    chk("ooo_r1", 64'(out_result), 64'hA1);
    chk("ooo_t1", out_tag, 64'hB);
    cyc();
    chk("ooo_v2", 64'(out_valid), 1);
    chk("ooo_r2", 64'(out_result), 64'hFFFF_FF80);
    cyc();
    out_ready = 0;
    chk("ooo_empty", 64'(count), 0);
    for (int i = 0; i < 4; i++) push(T_LW, 0, 0, 2'd0, 0, 0, 64'(i));
    chk("full_count", 64'(count), 4);
    chk("full_allowin", 64'(in_allowin), 0);
    resp(32'h1);
    chk("full_allowin_dok", 64'(in_allowin), 0);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("full_allowin_pop", 64'(in_allowin), 1);
    chk("full_count_pop", 64'(count), 3);
    out_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      resp(32'(i));
      chk("full_drain", 64'(out_result), 64'(i));
    end
    cyc();
    out_ready = 0;
    chk("full_empty", 64'(count), 0);
    push(T_LW, 0, 0, 2'd0, 0, 0, 64'h1);
    push(T_LW, 0, 0, 2'd0, 0, 0, 64'h2);
    flush = 1;
    cyc();
    flush = 0;
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(out_valid), 0);
    resp(32'hBAD0);
    resp(32'hBAD1);
    push(T_LW, 0, 0, 2'd0, 0, 0, 64'h7);
    chk("flush_new_wait", 64'(out_valid), 0);
    resp(32'h1234_5678);
    chk("flush_valid_new", 64'(out_valid), 1);
    chk("flush_result", 64'(out_result), 64'h1234_5678);
    chk("flush_tag", out_tag, 64'h7);
    chk("flush_resp_err", 64'(resp_err), 0);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("flush_empty", 64'(count), 0);
    mq.delete();
    mdrop = 0;
    merr = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 99) < 60;
      sel = $urandom_range(0, 9);
      in_load_type = sel < 7 ? 7'(1 << sel) : 7'd0;
      in_store = sel == 7;
      in_exc = $urandom_range(0, 9) == 0;
      in_offset = 2'($urandom);
      in_rt = $urandom;
      in_result = $urandom;
      in_tag = {$urandom, $urandom};
      data_ok = (mdrop > 0 || m_waiting() > 0) && $urandom_range(0, 99) < 45;
      rdata = $urandom;
      flush = $urandom_range(0, 99) < 4;
      out_ready = $urandom_range(0, 99) < 70;
      @(posedge clk);
      m_step();
      @(negedge clk);
      m_check();
    end
    idle();
    resetn = 0;
    #1;
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_allowin", 64'(in_allowin), 1);
    chk("mid_rst_resp_err", 64'(resp_err), 0);
    cyc();
    resetn = 1;
    cyc();
    push(T_LW, 0, 0, 2'd0, 0, 0, 64'h3);
    resp(32'hCAFE_F00D);
    chk("post_rst_result", 64'(out_result), 64'hCAFE_F00D);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("stray_pre", 64'(resp_err), 0);
    resp(32'h0);
    chk("stray_err", 64'(resp_err), 1);
    chk("stray_count", 64'(count), 0);
    repeat (3) cyc();
    chk("stray_sticky", 64'(resp_err), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
